// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read-port arbiter.
// Widths match the spi_flash controller's address and data ports.
package flash_pkg;

  localparam int   FLASH_AW      = 24;
  localparam int   FLASH_DW      = 32;
  localparam logic FLASH_WE_READ = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_BACKOFF = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last,
// searching cyclically; last itself is considered only after all others.
module rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         vld
);

  logic [W-1:0] cand;

  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(last) + i) % N);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one spi_flash read port between N_REQ requesters,
// with bounded retry/backoff on flash rty and a per-attempt watchdog.
module flash_arbiter
  import flash_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_RETRY = 8,
  parameter int BACKOFF   = 64,
  parameter int TIMEOUT   = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ*FLASH_AW-1:0]   req_adr_i,
  input  logic [N_REQ-1:0]            req_stb_i,
  output logic [FLASH_DW-1:0]         req_dat_o,
  output logic [N_REQ-1:0]            req_ack_o,
  output logic [N_REQ-1:0]            req_err_o,
  output logic [FLASH_AW-1:0]         flash_adr_o,
  output logic                        flash_stb_o,
  output logic                        flash_we_o,
  input  logic [FLASH_DW-1:0]         flash_dat_i,
  input  logic                        flash_ack_i,
  input  logic                        flash_rty_i,
  output logic                        busy_o,
  output logic [$clog2(N_REQ)-1:0]    gnt_o
);

  localparam int GW = $clog2(N_REQ);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BACKOFF + 1);

  state_t          state, state_nxt;
  logic [GW-1:0]   last_gnt;
  logic [RW-1:0]   retry_cnt;
  logic [WW-1:0]   wd_cnt;
  logic [BW-1:0]   bo_cnt;
  logic            dropped;

  logic [GW-1:0]   pick_idx;
  logic            pick_vld;
  logic [FLASH_AW-1:0] adr_arr [N_REQ];

  logic            retry_last;
  logic            wd_expired;
  logic            bo_done;
  logic            keep;
  logic [N_REQ-1:0] gnt_onehot;

  for (genvar g = 0; g < N_REQ; g++) begin : g_adr
    assign adr_arr[g] = req_adr_i[g*FLASH_AW +: FLASH_AW];
  end

  rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .req  (req_stb_i),
    .last (last_gnt),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign retry_last = (retry_cnt == RW'(MAX_RETRY - 1));
  assign wd_expired = (wd_cnt == WW'(TIMEOUT - 1));
  assign bo_done    = (bo_cnt == '0);
  // A requester that let go at any point in the transaction gets no pulse.
  assign keep       = req_stb_i[gnt_o] & ~dropped;
  assign gnt_onehot = N_REQ'(1) << gnt_o;
  assign flash_we_o = FLASH_WE_READ;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pick_vld) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (flash_ack_i)      state_nxt = ST_IDLE;
        else if (flash_rty_i) state_nxt = retry_last ? ST_IDLE : ST_BACKOFF;
        else if (wd_expired)  state_nxt = ST_IDLE;
      end
      ST_BACKOFF: if (bo_done) state_nxt = ST_BUSY;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state != ST_IDLE);
    flash_stb_o = (state == ST_BUSY);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_gnt    <= GW'(N_REQ - 1);
      gnt_o       <= '0;
      flash_adr_o <= '0;
      req_dat_o   <= '0;
      req_ack_o   <= '0;
      req_err_o   <= '0;
      retry_cnt   <= '0;
      wd_cnt      <= '0;
      bo_cnt      <= '0;
      dropped     <= 1'b0;
    end else begin
      req_ack_o <= '0;
      req_err_o <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_o       <= pick_idx;
            flash_adr_o <= adr_arr[pick_idx];
            retry_cnt   <= '0;
            wd_cnt      <= '0;
            dropped     <= 1'b0;
          end
        end
        ST_BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (!req_stb_i[gnt_o]) dropped <= 1'b1;
          if (flash_ack_i) begin
            req_dat_o <= flash_dat_i;
            if (keep) req_ack_o <= gnt_onehot;
            last_gnt <= gnt_o;
          end else if (flash_rty_i) begin
            if (retry_last) begin
              if (keep) req_err_o <= gnt_onehot;
              last_gnt <= gnt_o;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              bo_cnt    <= BW'(BACKOFF - 1);
            end
          end else if (wd_expired) begin
            if (keep) req_err_o <= gnt_onehot;
            last_gnt <= gnt_o;
          end
        end
        ST_BACKOFF: begin
          if (!req_stb_i[gnt_o]) dropped <= 1'b1;
          if (bo_done) wd_cnt <= '0;
          else         bo_cnt <= bo_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
